// File: rtl/multi_write_port.sv
// Multi-port write funnel: per-port index/data FIFOs, round-robin arbitration onto a
// single memory write port with out-of-range index filtering and a sticky error flag.
module multi_write_port #(
  parameter int unsigned NUM_PORTS    = 2,
  parameter int unsigned WORD_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned MEMORY_DEPTH = 256
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [NUM_PORTS-1:0]            index_valid,
  input  logic [NUM_PORTS*WORD_WIDTH-1:0] index_packet,
  output logic [NUM_PORTS-1:0]            index_ready,
  input  logic [NUM_PORTS-1:0]            data_valid,
  input  logic [NUM_PORTS*WORD_WIDTH-1:0] data_packet,
  output logic [NUM_PORTS-1:0]            data_ready,
  output logic                            write_enable,
  output logic [WORD_WIDTH-1:0]           write_index,
  output logic [WORD_WIDTH-1:0]           write_data,
  output logic [NUM_PORTS-1:0]            write_grant,
  output logic                            range_error,
  output logic                            quiescent
);

  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned PortW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [CntW-1:0]       FullCnt  = CntW'(FIFO_DEPTH);
  localparam logic [WORD_WIDTH:0]   MemLimit = (WORD_WIDTH + 1)'(MEMORY_DEPTH);

  logic [WORD_WIDTH-1:0] idx_mem_q [NUM_PORTS][FIFO_DEPTH];
  logic [WORD_WIDTH-1:0] dat_mem_q [NUM_PORTS][FIFO_DEPTH];

  logic [NUM_PORTS-1:0][PtrW-1:0] idx_wr_q, idx_wr_d, idx_rd_q, idx_rd_d;
  logic [NUM_PORTS-1:0][PtrW-1:0] dat_wr_q, dat_wr_d, dat_rd_q, dat_rd_d;
  logic [NUM_PORTS-1:0][CntW-1:0] idx_cnt_q, idx_cnt_d, dat_cnt_q, dat_cnt_d;
  logic [PortW-1:0]               rr_ptr_q, rr_ptr_d;
  logic                           range_error_q, range_error_d;

  logic [NUM_PORTS-1:0] idx_push, dat_push, pop, eligible;
  logic                 grant_valid;
  logic [PortW-1:0]     grant_port;
  logic [WORD_WIDTH-1:0] head_idx, head_dat;
  logic                 in_range;
  int unsigned          cand;

  // Ready is gated by reset so nothing is accepted while the FIFOs are held empty.
  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      index_ready[p] = enable & ~reset & (idx_cnt_q[p] != FullCnt);
      data_ready[p]  = enable & ~reset & (dat_cnt_q[p] != FullCnt);
      idx_push[p]    = index_valid[p] & index_ready[p];
      dat_push[p]    = data_valid[p] & data_ready[p];
      eligible[p]    = enable & (idx_cnt_q[p] != '0) & (dat_cnt_q[p] != '0);
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_port  = '0;
    cand        = 0;
    for (int unsigned off = 0; off < NUM_PORTS; off++) begin
      cand = 32'(rr_ptr_q) + off;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (!grant_valid && eligible[cand[PortW-1:0]]) begin
        grant_valid = 1'b1;
        grant_port  = cand[PortW-1:0];
      end
    end
  end

  always_comb begin
    head_idx     = idx_mem_q[grant_port][idx_rd_q[grant_port]];
    head_dat     = dat_mem_q[grant_port][dat_rd_q[grant_port]];
    in_range     = {1'b0, head_idx} < MemLimit;
    write_grant  = grant_valid ? (NUM_PORTS'(1) << grant_port) : '0;
    write_enable = grant_valid & in_range;
    write_index  = grant_valid ? head_idx : '0;
    write_data   = grant_valid ? head_dat : '0;
    pop          = write_grant;
    range_error  = range_error_q;
  end

  always_comb begin
    quiescent = 1'b1;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (idx_cnt_q[p] != '0 || dat_cnt_q[p] != '0) quiescent = 1'b0;
    end
  end

  always_comb begin
    range_error_d = range_error_q | (grant_valid & ~in_range);
    rr_ptr_d      = rr_ptr_q;
    if (grant_valid) begin
      if (32'(grant_port) == NUM_PORTS - 1) rr_ptr_d = '0;
      else                                 rr_ptr_d = grant_port + PortW'(1);
    end
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      idx_wr_d[p]  = idx_push[p] ? idx_wr_q[p] + PtrW'(1) : idx_wr_q[p];
      dat_wr_d[p]  = dat_push[p] ? dat_wr_q[p] + PtrW'(1) : dat_wr_q[p];
      idx_rd_d[p]  = pop[p] ? idx_rd_q[p] + PtrW'(1) : idx_rd_q[p];
      dat_rd_d[p]  = pop[p] ? dat_rd_q[p] + PtrW'(1) : dat_rd_q[p];
      idx_cnt_d[p] = idx_cnt_q[p] + CntW'(idx_push[p]) - CntW'(pop[p]);
      dat_cnt_d[p] = dat_cnt_q[p] + CntW'(dat_push[p]) - CntW'(pop[p]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_wr_q      <= '0;
      idx_rd_q      <= '0;
      dat_wr_q      <= '0;
      dat_rd_q      <= '0;
      idx_cnt_q     <= '0;
      dat_cnt_q     <= '0;
      rr_ptr_q      <= '0;
      range_error_q <= 1'b0;
    end else begin
      idx_wr_q      <= idx_wr_d;
      idx_rd_q      <= idx_rd_d;
      dat_wr_q      <= dat_wr_d;
      dat_rd_q      <= dat_rd_d;
      idx_cnt_q     <= idx_cnt_d;
      dat_cnt_q     <= dat_cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      range_error_q <= range_error_d;
    end
  end

  // Storage needs no reset: occupancy counters alone define which entries are live.
  always_ff @(posedge clock) begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (idx_push[p]) idx_mem_q[p][idx_wr_q[p]] <= index_packet[p*WORD_WIDTH +: WORD_WIDTH];
      if (dat_push[p]) dat_mem_q[p][dat_wr_q[p]] <= data_packet[p*WORD_WIDTH +: WORD_WIDTH];
    end
  end

endmodule

// File: tb/tb_multi_write_port.sv
// Scoreboard bench for multi_write_port: expected writes are queued per port when a
// complete pair is offered and popped when the DUT grants that port.
module tb_multi_write_port;
  localparam int NP = 2;
  localparam int WW = 32;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b1;
  logic [NP-1:0]      index_valid = '0;
  logic [NP*WW-1:0]   index_packet = '0;
  logic [NP-1:0]      index_ready;
  logic [NP-1:0]      data_valid = '0;
  logic [NP*WW-1:0]   data_packet = '0;
  logic [NP-1:0]      data_ready;
  logic               write_enable;
  logic [WW-1:0]      write_index;
  logic [WW-1:0]      write_data;
  logic [NP-1:0]      write_grant;
  logic               range_error;
  logic               quiescent;

  typedef struct packed {
    logic [WW-1:0] idx;
    logic [WW-1:0] dat;
    logic          we;
  } exp_t;

  exp_t sb [NP][$];
  int   n_cmp = 0;
  int   n_bad = 0;

  multi_write_port #(
    .NUM_PORTS(NP), .WORD_WIDTH(WW), .FIFO_DEPTH(2), .MEMORY_DEPTH(256)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .index_valid(index_valid), .index_packet(index_packet), .index_ready(index_ready),
    .data_valid(data_valid), .data_packet(data_packet), .data_ready(data_ready),
    .write_enable(write_enable), .write_index(write_index), .write_data(write_data),
    .write_grant(write_grant), .range_error(range_error), .quiescent(quiescent)
  );

  always #5 clock = ~clock;

  task automatic idle();
    index_valid = '0;
    data_valid  = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    idle();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int p = 0; p < NP; p++) sb[p].delete();
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1; enable = 1'b1; idle();
    @(negedge clock);
    n_cmp++; if ({write_enable, write_grant} !== 3'b000) begin n_bad++;
      $display("FAIL reset_grant: got we=%b grant=%b expected 0/00", write_enable, write_grant); end
    n_cmp++; if ({write_index, write_data} !== '0) begin n_bad++;
      $display("FAIL reset_words: got %h/%h expected 0/0", write_index, write_data); end
    n_cmp++; if ({index_ready, data_ready} !== 4'b0000) begin n_bad++;
      $display("FAIL reset_ready: got %b/%b expected 00/00", index_ready, data_ready); end
    n_cmp++; if ({quiescent, range_error} !== 2'b10) begin n_bad++;
      $display("FAIL reset_flags: got q=%b re=%b expected 1/0", quiescent, range_error); end
    reset = 1'b0;
    @(negedge clock);
    n_cmp++; if ({index_ready, data_ready} !== 4'b1111) begin n_bad++;
      $display("FAIL post_reset_ready: got %b/%b expected 11/11", index_ready, data_ready); end
    e = '0;
  endtask

  task automatic test_skew();
    exp_t e;
    index_valid = 2'b01; index_packet[0 +: WW] = 32'd5;
    @(negedge clock);
    idle();
    n_cmp++; if (write_grant !== 2'b00 || quiescent !== 1'b0) begin n_bad++;
      $display("FAIL skew_index_only: got grant=%b q=%b expected 00/0", write_grant, quiescent); end
    @(negedge clock);
    data_valid = 2'b01; data_packet[0 +: WW] = 32'hDEADBEEF;
    sb[0].push_back('{idx: 32'd5, dat: 32'hDEADBEEF, we: 1'b1});
    @(negedge clock);
    idle();
    n_cmp++; if (write_grant !== 2'b01) begin n_bad++;
      $display("FAIL skew_grant: got %b expected 01", write_grant); end
    if (sb[0].size() > 0) begin
      e = sb[0].pop_front();
      n_cmp++; if ({write_enable, write_index, write_data} !== {e.we, e.idx, e.dat}) begin
        n_bad++; $display("FAIL skew_write: got we=%b %h/%h expected %b %h/%h",
                          write_enable, write_index, write_data, e.we, e.idx, e.dat); end
    end
    @(negedge clock);
    n_cmp++; if (write_grant !== 2'b00 || quiescent !== 1'b1) begin n_bad++;
      $display("FAIL skew_drained: got grant=%b q=%b expected 00/1", write_grant, quiescent); end
  endtask

  task automatic test_round_robin();
    exp_t          e;
    int            pushed [NP];
    int            writes;
    int            port;
    logic [NP-1:0] exp_g;
    logic [WW-1:0] d;
    pulse_reset();
    pushed = '{0, 0}; writes = 0; exp_g = 2'b01;
    for (int cyc = 0; cyc < 80 && writes < 12; cyc++) begin
      @(negedge clock);
      if (write_grant !== 2'b00) begin
        n_cmp++; if (write_grant !== exp_g) begin n_bad++;
          $display("FAIL rr_grant: got %b expected %b (write %0d)", write_grant, exp_g, writes); end
        port = write_grant[1] ? 1 : 0;
        if (sb[port].size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL rr_extra: got write on port %0d expected none", port);
        end else begin
          e = sb[port].pop_front();
          n_cmp++; if ({write_enable, write_index, write_data} !== {e.we, e.idx, e.dat}) begin
            n_bad++; $display("FAIL rr_write: got we=%b %h/%h expected %b %h/%h",
                              write_enable, write_index, write_data, e.we, e.idx, e.dat); end
        end
        exp_g = {exp_g[NP-2:0], exp_g[NP-1]};
        writes++;
      end
      idle();
      for (int p = 0; p < NP; p++) begin
        if (pushed[p] < 6 && index_ready[p] && data_ready[p]) begin
          d = $urandom;
          index_valid[p] = 1'b1; index_packet[p*WW +: WW] = 32'(p * 16 + pushed[p]);
          data_valid[p]  = 1'b1; data_packet[p*WW +: WW]  = d;
          sb[p].push_back('{idx: 32'(p * 16 + pushed[p]), dat: d, we: 1'b1});
          pushed[p]++;
        end
      end
    end
    idle();
    n_cmp++; if (writes != 12) begin n_bad++;
      $display("FAIL rr_count: got %0d writes expected 12", writes); end
    @(negedge clock);
    n_cmp++; if (quiescent !== 1'b1) begin n_bad++;
      $display("FAIL rr_quiescent: got %b expected 1", quiescent); end
  endtask

  task automatic test_range_error();
    index_valid = 2'b10; index_packet[WW +: WW] = 32'd300;
    data_valid  = 2'b10; data_packet[WW +: WW]  = 32'd7;
    @(negedge clock);
    idle();
    n_cmp++; if ({write_grant, write_enable} !== 3'b100) begin n_bad++;
      $display("FAIL range_grant: got grant=%b we=%b expected 10/0", write_grant, write_enable); end
    n_cmp++; if ({write_index, write_data} !== {32'd300, 32'd7}) begin n_bad++;
      $display("FAIL range_words: got %0d/%0d expected 300/7", write_index, write_data); end
    @(negedge clock);
    n_cmp++; if ({range_error, quiescent, write_grant} !== 4'b1100) begin n_bad++;
      $display("FAIL range_after: got re=%b q=%b grant=%b expected 1/1/00",
               range_error, quiescent, write_grant); end
  endtask

  task automatic test_backpressure();
    exp_t e;
    index_valid = 2'b01; index_packet[0 +: WW] = 32'd10;
    @(negedge clock);
    n_cmp++; if (index_ready[0] !== 1'b1) begin n_bad++;
      $display("FAIL bp_one_entry: got index_ready0=%b expected 1", index_ready[0]); end
    index_packet[0 +: WW] = 32'd11;
    @(negedge clock);
    idle();
    n_cmp++; if ({index_ready[0], data_ready[0], write_grant} !== 4'b0100) begin n_bad++;
      $display("FAIL bp_full: got ir=%b dr=%b grant=%b expected 0/1/00",
               index_ready[0], data_ready[0], write_grant); end
    data_valid = 2'b01; data_packet[0 +: WW] = 32'hA;
    sb[0].push_back('{idx: 32'd10, dat: 32'hA, we: 1'b1});
    @(negedge clock);
    idle();
    n_cmp++; if (write_grant !== 2'b01 || index_ready[0] !== 1'b0) begin n_bad++;
      $display("FAIL bp_pop_cycle: got grant=%b ir=%b expected 01/0", write_grant, index_ready[0]); end
    if (sb[0].size() > 0) begin
      e = sb[0].pop_front();
      n_cmp++; if ({write_enable, write_index, write_data} !== {e.we, e.idx, e.dat}) begin
        n_bad++; $display("FAIL bp_write: got we=%b %h/%h expected %b %h/%h",
                          write_enable, write_index, write_data, e.we, e.idx, e.dat); end
    end
    @(negedge clock);
    n_cmp++; if (index_ready[0] !== 1'b1 || write_grant !== 2'b00) begin n_bad++;
      $display("FAIL bp_freed: got ir=%b grant=%b expected 1/00", index_ready[0], write_grant); end
    data_valid = 2'b01; data_packet[0 +: WW] = 32'hB;
    sb[0].push_back('{idx: 32'd11, dat: 32'hB, we: 1'b1});
    @(negedge clock);
    idle();
    if (sb[0].size() > 0) begin
      e = sb[0].pop_front();
      n_cmp++; if ({write_grant, write_enable, write_index, write_data} !==
                   {2'b01, e.we, e.idx, e.dat}) begin
        n_bad++; $display("FAIL bp_second: got grant=%b we=%b %h/%h expected 01 %b %h/%h",
                          write_grant, write_enable, write_index, write_data, e.we, e.idx, e.dat);
      end
    end
  endtask

  task automatic test_enable();
    exp_t e;
    int   bad_hold;
    @(negedge clock);
    index_valid = 2'b11; index_packet = {32'd21, 32'd20};
    data_valid  = 2'b11; data_packet  = {32'hC1, 32'hC0};
    sb[0].push_back('{idx: 32'd20, dat: 32'hC0, we: 1'b1});
    sb[1].push_back('{idx: 32'd21, dat: 32'hC1, we: 1'b1});
    @(negedge clock);
    idle();
    enable = 1'b0;
    bad_hold = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (write_grant !== 2'b00 || write_enable !== 1'b0 || index_ready !== 2'b00 ||
          data_ready !== 2'b00 || quiescent !== 1'b0 || range_error !== 1'b1) bad_hold++;
      @(negedge clock);
    end
    n_cmp++; if (bad_hold != 0) begin n_bad++;
      $display("FAIL enable_hold: got %0d disturbed cycles expected 0", bad_hold); end
    enable = 1'b1;
    #1;
    n_cmp++; if (write_grant !== 2'b10) begin n_bad++;
      $display("FAIL enable_resume_first: got %b expected 10", write_grant); end
    if (sb[1].size() > 0) begin
      e = sb[1].pop_front();
      n_cmp++; if ({write_enable, write_index, write_data} !== {e.we, e.idx, e.dat}) begin
        n_bad++; $display("FAIL enable_write1: got we=%b %h/%h expected %b %h/%h",
                          write_enable, write_index, write_data, e.we, e.idx, e.dat); end
    end
    @(negedge clock);
    n_cmp++; if (write_grant !== 2'b01) begin n_bad++;
      $display("FAIL enable_resume_second: got %b expected 01", write_grant); end
    if (sb[0].size() > 0) begin
      e = sb[0].pop_front();
      n_cmp++; if ({write_enable, write_index, write_data} !== {e.we, e.idx, e.dat}) begin
        n_bad++; $display("FAIL enable_write0: got we=%b %h/%h expected %b %h/%h",
                          write_enable, write_index, write_data, e.we, e.idx, e.dat); end
    end
    @(negedge clock);
    n_cmp++; if (quiescent !== 1'b1) begin n_bad++;
      $display("FAIL enable_drained: got %b expected 1", quiescent); end
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    int   late;
    data_valid = 2'b11; data_packet = {32'hD1A, 32'hD0A};
    @(negedge clock);
    data_packet = {32'hD1B, 32'hD0B};
    @(negedge clock);
    idle();
    index_valid = 2'b11; index_packet = {32'd41, 32'd40};
    sb[0].push_back('{idx: 32'd40, dat: 32'hD0A, we: 1'b1});
    sb[1].push_back('{idx: 32'd41, dat: 32'hD1A, we: 1'b1});
    @(negedge clock);
    n_cmp++; if (write_grant !== 2'b10) begin n_bad++;
      $display("FAIL mid_first_grant: got %b expected 10", write_grant); end
    if (sb[1].size() > 0) begin
      e = sb[1].pop_front();
      n_cmp++; if ({write_enable, write_index, write_data} !== {e.we, e.idx, e.dat}) begin
        n_bad++; $display("FAIL mid_write1: got we=%b %h/%h expected %b %h/%h",
                          write_enable, write_index, write_data, e.we, e.idx, e.dat); end
    end
    index_packet = {32'd43, 32'd42};
    @(negedge clock);
    idle();
    n_cmp++; if (write_grant !== 2'b01 || write_index !== 32'd40) begin n_bad++;
      $display("FAIL mid_second_grant: got %b idx %0d expected 01 idx 40", write_grant, write_index);
    end
    reset = 1'b1;
    #1;
    n_cmp++; if ({write_enable, write_grant, write_index, write_data} !== '0) begin n_bad++;
      $display("FAIL mid_reset_outputs: got we=%b grant=%b %h/%h expected all 0",
               write_enable, write_grant, write_index, write_data); end
    n_cmp++; if ({quiescent, range_error, index_ready, data_ready} !== 6'b100000) begin n_bad++;
      $display("FAIL mid_reset_flags: got q=%b re=%b ir=%b dr=%b expected 1/0/00/00",
               quiescent, range_error, index_ready, data_ready); end
    for (int p = 0; p < NP; p++) sb[p].delete();
    @(negedge clock);
    reset = 1'b0;
    late = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (write_grant !== 2'b00 || write_enable !== 1'b0 || quiescent !== 1'b1) late++;
    end
    n_cmp++; if (late != 0) begin n_bad++;
      $display("FAIL mid_after_release: got %0d cycles with activity expected 0", late); end
  endtask

  initial begin
    test_reset();
    test_skew();
    test_round_robin();
    test_range_error();
    test_backpressure();
    test_enable();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
